// File: rtl/fsk_pkg.sv
// -----------------------------------------------------------------------------
// fsk_pkg
// Shared definitions for the zero-crossing FSK demodulator:
//   - fsk_state_t   : bit-timing state (IDLE = searching, ACQ = locked)
//   - FSK_*         : default oversampling ratio, word width and slice threshold
//   - fsk_cnt_width : bits needed to hold a counter value 0..n
// -----------------------------------------------------------------------------
package fsk_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACQ  = 1'b1
    } fsk_state_t;

    localparam int FSK_SAMPLES_PER_BIT = 16;
    localparam int FSK_WORD_BITS       = 12;
    localparam int FSK_EDGE_THRESH     = 6;

    // Width of a counter that must represent every value from 0 to n.
    function automatic int fsk_cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fsk_edge_detect.sv
// -----------------------------------------------------------------------------
// fsk_edge_detect
// Brings the asynchronous FSK line into the clk domain and flags every
// transition of the conditioned signal for one cycle.
//
// Optional feature macro: FSK_DEMOD_GLITCH_FILTER_EN
//   defined   : majority-of-3 filter over the last three synchronized samples
//               before edge detection; single-cycle pulses are suppressed and
//               pin-to-flag latency is 3 cycles.
//   undefined : every synchronized change is an edge; latency is 2 cycles.
//
// Ports:
//   clk    in  receiver oversampling clock
//   reset  in  asynchronous active-high reset
//   i_din  in  raw FSK line (asynchronous)
//   o_edge out one-cycle edge flag
// -----------------------------------------------------------------------------
module fsk_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic i_din,
    output logic o_edge
);

    // r_sync1/r_sync2 form the metastability synchronizer; r_sync3 is the
    // one-cycle-delayed copy used for edge detection.
    logic r_sync1;
    logic r_sync2;
    logic r_sync3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= i_din;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

`ifdef FSK_DEMOD_GLITCH_FILTER_EN
    logic r_sync4;
    logic r_filt;
    logic w_maj;

    // A level must persist for two of the last three samples to be accepted.
    assign w_maj = (r_sync2 & r_sync3) | (r_sync2 & r_sync4) | (r_sync3 & r_sync4);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync4 <= 1'b0;
            r_filt  <= 1'b0;
        end else begin
            r_sync4 <= r_sync3;
            r_filt  <= w_maj;
        end
    end

    assign o_edge = w_maj ^ r_filt;
`else
    assign o_edge = r_sync2 ^ r_sync3;
`endif

endmodule

// File: rtl/fsk_zc_demod.sv
// -----------------------------------------------------------------------------
// fsk_zc_demod
// Zero-crossing FSK demodulator and word assembler. Counts line transitions in
// each SAMPLES_PER_BIT window, slices mark/space against EDGE_THRESH, and packs
// WORD_BITS bits MSB-first into a codeword. A window with no edges is treated
// as carrier loss: the partial word is dropped and timing is re-acquired on
// the next edge.
//
// Optional feature macro: FSK_DEMOD_GLITCH_FILTER_EN (see fsk_edge_detect).
//
// Ports:
//   clk      in  receiver oversampling clock
//   reset    in  asynchronous active-high reset
//   datain   in  raw FSK line (asynchronous)
//   dataout  out last completed codeword, held until the next one
//   valid    out one-cycle pulse when dataout updates
//   carrier  out high while bit timing is locked
// -----------------------------------------------------------------------------
module fsk_zc_demod
    import fsk_pkg::*;
#(
    parameter int SAMPLES_PER_BIT = FSK_SAMPLES_PER_BIT,
    parameter int WORD_BITS       = FSK_WORD_BITS,
    parameter int EDGE_THRESH     = FSK_EDGE_THRESH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 datain,
    output logic [WORD_BITS-1:0] dataout,
    output logic                 valid,
    output logic                 carrier
);

    localparam int SW = fsk_cnt_width(SAMPLES_PER_BIT - 1);
    localparam int EW = fsk_cnt_width(SAMPLES_PER_BIT);
    localparam int BW = fsk_cnt_width(WORD_BITS - 1);

    fsk_state_t           r_state, w_state_next;
    logic [SW-1:0]        r_sample_cnt, w_sample_cnt_next;
    logic [EW-1:0]        r_edge_cnt, w_edge_cnt_next, w_edge_total;
    logic [BW-1:0]        r_bit_cnt, w_bit_cnt_next;
    logic [WORD_BITS-1:0] r_shift, w_shift_next, w_shift_in;
    logic [WORD_BITS-1:0] r_dataout, w_dataout_next;
    logic                 r_valid, w_valid_next;
    logic                 w_edge, w_last, w_bit;

    fsk_edge_detect u_edge (
        .clk    (clk),
        .reset  (reset),
        .i_din  (datain),
        .o_edge (w_edge)
    );

    // Edge count for the window including the current cycle, saturating.
    assign w_edge_total = (r_edge_cnt == EW'(SAMPLES_PER_BIT)) ? r_edge_cnt
                                                                : r_edge_cnt + EW'(w_edge);
    assign w_last     = (r_sample_cnt == SW'(SAMPLES_PER_BIT - 1));
    assign w_bit      = (w_edge_total >= EW'(EDGE_THRESH));
    assign w_shift_in = {r_shift[WORD_BITS-2:0], w_bit};

    always_comb begin
        w_state_next      = r_state;
        w_sample_cnt_next = r_sample_cnt;
        w_edge_cnt_next   = r_edge_cnt;
        w_bit_cnt_next    = r_bit_cnt;
        w_shift_next      = r_shift;
        w_dataout_next    = r_dataout;
        w_valid_next      = 1'b0;
        case (r_state)
            IDLE: begin
                // The acquiring edge's cycle is sample 0 of window 0 and
                // already contributes one edge.
                if (w_edge) begin
                    w_state_next      = ACQ;
                    w_sample_cnt_next = SW'(1);
                    w_edge_cnt_next   = EW'(1);
                    w_bit_cnt_next    = '0;
                    w_shift_next      = '0;
                end
            end
            ACQ: begin
                if (!w_last) begin
                    w_sample_cnt_next = r_sample_cnt + SW'(1);
                    w_edge_cnt_next   = w_edge_total;
                end else if (w_edge_total == '0) begin
                    // Silent window: carrier gone, drop the partial word.
                    w_state_next      = IDLE;
                    w_sample_cnt_next = '0;
                    w_edge_cnt_next   = '0;
                    w_bit_cnt_next    = '0;
                    w_shift_next      = '0;
                end else begin
                    // The boundary cycle's edge also seeds the next window.
                    w_sample_cnt_next = '0;
                    w_edge_cnt_next   = EW'(w_edge);
                    w_shift_next      = w_shift_in;
                    if (r_bit_cnt == BW'(WORD_BITS - 1)) begin
                        w_bit_cnt_next = '0;
                        w_dataout_next = w_shift_in;
                        w_valid_next   = 1'b1;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + BW'(1);
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_sample_cnt <= '0;
            r_edge_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_dataout    <= '0;
            r_valid      <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_sample_cnt <= w_sample_cnt_next;
            r_edge_cnt   <= w_edge_cnt_next;
            r_bit_cnt    <= w_bit_cnt_next;
            r_shift      <= w_shift_next;
            r_dataout    <= w_dataout_next;
            r_valid      <= w_valid_next;
        end
    end

    assign dataout = r_dataout;
    assign valid   = r_valid;
    assign carrier = (r_state == ACQ);

endmodule

// File: tb/tb_fsk_zc_demod.sv
`timescale 1ns/1ps
module tb_fsk_zc_demod;

    localparam int SPB      = 16;
    localparam int WB       = 12;
    localparam int TH       = 6;
    localparam int WORD_CYC = SPB * WB;
    localparam int MAXN     = 1024;
`ifdef FSK_DEMOD_GLITCH_FILTER_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          datain = 1'b0;
    logic [WB-1:0] dataout;
    logic          valid;
    logic          carrier;

    fsk_zc_demod #(
        .SAMPLES_PER_BIT (SPB),
        .WORD_BITS       (WB),
        .EDGE_THRESH     (TH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .datain  (datain),
        .dataout (dataout),
        .valid   (valid),
        .carrier (carrier)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Stimulus as a list of toggle positions; lv is the resulting line level.
    bit            tog[MAXN];
    bit            lv[MAXN];
    int            nlen;
    bit            ob_valid[MAXN], ob_car[MAXN];
    logic [WB-1:0] ob_data[MAXN];
    bit            ex_valid[MAXN], ex_car[MAXN];
    logic [WB-1:0] ex_data[MAXN];

    task automatic clear_stim(input int n);
        nlen = n;
        for (int i = 0; i < MAXN; i++) tog[i] = 1'b0;
    endtask

    // Place ne evenly spaced transitions at the start of a bit window.
    task automatic add_window(input int pos, input int ne);
        int sp;
        sp = (ne <= 4) ? 4 : 2;
        for (int e = 0; e < ne; e++) tog[pos + e * sp] = 1'b1;
    endtask

    task automatic add_word(input int pos, input logic [WB-1:0] w);
        for (int i = 0; i < WB; i++) add_window(pos + i * SPB, w[WB-1-i] ? 8 : 4);
    endtask

    // Reference model: derives the edge-flag timeline from the line, then
    // walks bit windows arithmetically to predict valid/carrier/dataout as
    // observed after each clock edge.
    task automatic build_expected(input logic [WB-1:0] d0);
        bit            x[MAXN];
        bit            fl[MAXN + 4];
        bit            prev;
        logic [WB-1:0] cur, word;
        int            k, e, w, s, l, cnt, nb;
        prev = 1'b0;
        for (int n = 0; n < nlen; n++) begin
            prev  = prev ^ tog[n];
            lv[n] = prev;
        end
        for (int n = 0; n < nlen; n++) begin
`ifdef FSK_DEMOD_GLITCH_FILTER_EN
            int ones;
            ones = int'(lv[n]) + ((n >= 1) ? int'(lv[n-1]) : 0) + ((n >= 2) ? int'(lv[n-2]) : 0);
            x[n] = (ones >= 2);
`else
            x[n] = lv[n];
`endif
        end
        for (int n = 0; n < MAXN + 4; n++) fl[n] = 1'b0;
        for (int n = 0; n < nlen; n++)
            if (x[n] != ((n > 0) ? x[n-1] : 1'b0)) fl[n + 2] = 1'b1;
        for (int n = 0; n < nlen; n++) begin
            ex_valid[n] = 1'b0;
            ex_car[n]   = 1'b0;
            ex_data[n]  = d0;
        end
        cur = d0;
        k   = 0;
        while (k < nlen) begin
            e = k;
            while (e < nlen && !fl[e]) e++;
            if (e >= nlen) break;
            w    = 0;
            word = '0;
            nb   = 0;
            forever begin
                s = e + w * SPB;
                l = s + SPB - 1;
                if (l >= nlen) begin
                    for (int m = e; m < nlen; m++) ex_car[m] = 1'b1;
                    k = nlen;
                    break;
                end
                cnt = (w > 0) ? int'(fl[s-1]) : 0;
                for (int m = s; m <= l; m++) cnt += int'(fl[m]);
                if (cnt > SPB) cnt = SPB;
                if (cnt == 0) begin
                    for (int m = e; m < l; m++) ex_car[m] = 1'b1;
                    k = l + 1;
                    break;
                end
                word = {word[WB-2:0], (cnt >= TH)};
                nb++;
                if (nb == WB) begin
                    ex_valid[l] = 1'b1;
                    cur = word;
                    for (int m = l; m < nlen; m++) ex_data[m] = cur;
                    nb = 0;
                end
                w++;
            end
        end
    endtask

    // Drives lv sample by sample and records outputs after each rising edge.
    task automatic run_line();
        for (int n = 0; n < nlen; n++) begin
            datain = lv[n];
            @(posedge clk);
            @(negedge clk);
            ob_valid[n] = valid;
            ob_car[n]   = carrier;
            ob_data[n]  = dataout;
        end
    endtask

    task automatic do_reset();
        datain = 1'b0;
        reset  = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        // Reset held while the line toggles.
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            datain = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if ({valid, carrier, dataout} !== '0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: valid=%0b carrier=%0b dataout=%h, want all 0", i, valid, carrier, dataout);
            end
        end
        datain = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({valid, carrier, dataout} !== '0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: valid=%0b carrier=%0b dataout=%h, want all 0", i, valid, carrier, dataout);
            end
        end
        // Mid-word asynchronous reset after one word has completed.
        clear_stim(5 + 2 * WORD_CYC);
        add_word(5, 12'hA5C);
        add_word(5 + WORD_CYC, 12'h3C3);
        build_expected('0);
        for (int n = 0; n < 5 + WORD_CYC + 60; n++) begin
            datain = lv[n];
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (dataout !== 12'hA5C || carrier !== 1'b1) begin
            errors++;
            $display("FAIL reset_preword: dataout=%h carrier=%0b, want a5c/1", dataout, carrier);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({valid, carrier, dataout} !== '0) begin
            errors++;
            $display("FAIL reset_async: valid=%0b carrier=%0b dataout=%h, want all 0", valid, carrier, dataout);
        end
        repeat (3) @(negedge clk);
        datain = 1'b0;
        reset  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checks++;
            if ({valid, carrier, dataout} !== '0) begin
                errors++;
                $display("FAIL reset_after_release cycle %0d: valid=%0b carrier=%0b dataout=%h, want all 0", i, valid, carrier, dataout);
            end
        end
    endtask

    task automatic test_single_word();
        int pidx[$];
        do_reset();
        clear_stim(5 + WORD_CYC + 40);
        add_word(5, 12'hA5C);
        build_expected('0);
        run_line();
        for (int n = 0; n < nlen; n++) begin
            checks++;
            if (ob_valid[n] !== ex_valid[n] || ob_car[n] !== ex_car[n] || ob_data[n] !== ex_data[n]) begin
                errors++;
                $display("FAIL single_word cycle %0d: valid/carrier/dataout=%0b/%0b/%h, want %0b/%0b/%h",
                         n, ob_valid[n], ob_car[n], ob_data[n], ex_valid[n], ex_car[n], ex_data[n]);
            end
            if (ob_valid[n]) pidx.push_back(n);
        end
        checks++;
        if (pidx.size() != 1) begin
            errors++;
            $display("FAIL single_word_pulses: got %0d valid pulses, want 1", pidx.size());
        end else begin
            checks++;
            if (pidx[0] != 5 + LAT + WORD_CYC - 1 || ob_data[pidx[0]] !== 12'hA5C) begin
                errors++;
                $display("FAIL single_word_value: pulse at %0d data %h, want %0d data a5c", pidx[0], ob_data[pidx[0]], 5 + LAT + WORD_CYC - 1);
            end
            checks++;
            if (ob_car[5 + LAT] !== 1'b1 || ob_car[5 + LAT - 1] !== 1'b0) begin
                errors++;
                $display("FAIL single_word_carrier_rise: carrier around acquisition %0b%0b, want 01", ob_car[5 + LAT - 1], ob_car[5 + LAT]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int pidx[$];
        do_reset();
        clear_stim(5 + 2 * WORD_CYC + 30);
        add_word(5, 12'h000);
        add_word(5 + WORD_CYC, 12'hFFF);
        build_expected('0);
        run_line();
        for (int n = 0; n < nlen; n++) begin
            checks++;
            if (ob_valid[n] !== ex_valid[n] || ob_car[n] !== ex_car[n] || ob_data[n] !== ex_data[n]) begin
                errors++;
                $display("FAIL back_to_back cycle %0d: valid/carrier/dataout=%0b/%0b/%h, want %0b/%0b/%h",
                         n, ob_valid[n], ob_car[n], ob_data[n], ex_valid[n], ex_car[n], ex_data[n]);
            end
            if (ob_valid[n]) pidx.push_back(n);
        end
        checks++;
        if (pidx.size() != 2) begin
            errors++;
            $display("FAIL back_to_back_pulses: got %0d valid pulses, want 2", pidx.size());
        end else begin
            checks++;
            if (pidx[1] - pidx[0] != WORD_CYC || ob_data[pidx[0]] !== 12'h000 || ob_data[pidx[1]] !== 12'hFFF) begin
                errors++;
                $display("FAIL back_to_back_values: spacing %0d data %h,%h, want %0d 000,fff",
                         pidx[1] - pidx[0], ob_data[pidx[0]], ob_data[pidx[1]], WORD_CYC);
            end
        end
    endtask

    task automatic test_carrier_loss();
        int            pidx[$];
        int            e, l;
        logic [WB-1:0] w;
        do_reset();
        w = 12'($urandom);
        clear_stim(125 + WORD_CYC + 30);
        for (int i = 0; i < 5; i++) add_window(5 + i * SPB, w[WB-1-i] ? 8 : 4);
        add_word(125, 12'h3C3);
        build_expected('0);
        run_line();
        for (int n = 0; n < nlen; n++) begin
            checks++;
            if (ob_valid[n] !== ex_valid[n] || ob_car[n] !== ex_car[n] || ob_data[n] !== ex_data[n]) begin
                errors++;
                $display("FAIL carrier_loss cycle %0d: valid/carrier/dataout=%0b/%0b/%h, want %0b/%0b/%h",
                         n, ob_valid[n], ob_car[n], ob_data[n], ex_valid[n], ex_car[n], ex_data[n]);
            end
            if (ob_valid[n]) pidx.push_back(n);
        end
        e = 5 + LAT;
        l = e + 5 * SPB + SPB - 1;
        checks++;
        if (ob_car[l-1] !== 1'b1 || ob_car[l] !== 1'b0) begin
            errors++;
            $display("FAIL carrier_loss_fall: carrier at %0d,%0d = %0b%0b, want 10", l - 1, l, ob_car[l-1], ob_car[l]);
        end
        checks++;
        if (pidx.size() != 1) begin
            errors++;
            $display("FAIL carrier_loss_pulses: got %0d valid pulses, want 1", pidx.size());
        end else begin
            checks++;
            if (pidx[0] != 125 + LAT + WORD_CYC - 1 || ob_data[pidx[0]] !== 12'h3C3) begin
                errors++;
                $display("FAIL carrier_loss_reacq: pulse at %0d data %h, want %0d data 3c3", pidx[0], ob_data[pidx[0]], 125 + LAT + WORD_CYC - 1);
            end
        end
    endtask

    task automatic test_threshold();
        int            pidx[$];
        int            ne[2*WB] = '{6, 5, 6, 5, 8, 4, 8, 4, 6, 5, 7, 3,
                                    5, 6, 5, 6, 4, 8, 4, 8, 5, 6, 3, 7};
        logic [WB-1:0] want[2] = '{12'hAAA, 12'h555};
        do_reset();
        clear_stim(5 + 2 * WORD_CYC + 30);
        for (int i = 0; i < 2 * WB; i++) add_window(5 + i * SPB, ne[i]);
        build_expected('0);
        run_line();
        for (int n = 0; n < nlen; n++) begin
            checks++;
            if (ob_valid[n] !== ex_valid[n] || ob_car[n] !== ex_car[n] || ob_data[n] !== ex_data[n]) begin
                errors++;
                $display("FAIL threshold cycle %0d: valid/carrier/dataout=%0b/%0b/%h, want %0b/%0b/%h",
                         n, ob_valid[n], ob_car[n], ob_data[n], ex_valid[n], ex_car[n], ex_data[n]);
            end
            if (ob_valid[n]) pidx.push_back(n);
        end
        checks++;
        if (pidx.size() != 2) begin
            errors++;
            $display("FAIL threshold_pulses: got %0d valid pulses, want 2", pidx.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (ob_data[pidx[i]] !== want[i]) begin
                    errors++;
                    $display("FAIL threshold_word%0d: dataout=%h, want %h", i, ob_data[pidx[i]], want[i]);
                end
            end
        end
    endtask

    task automatic test_random_words();
        int            pidx[$];
        logic [WB-1:0] w[3];
        int            pos;
        do_reset();
        pos = int'($urandom_range(3, 20));
        clear_stim(pos + 3 * WORD_CYC + 30);
        for (int k = 0; k < 3; k++) begin
            w[k] = 12'($urandom);
            for (int i = 0; i < WB; i++)
                add_window(pos + (k * WB + i) * SPB,
                           w[k][WB-1-i] ? int'($urandom_range(TH, 8)) : int'($urandom_range(1, TH - 1)));
        end
        build_expected('0);
        run_line();
        for (int n = 0; n < nlen; n++) begin
            checks++;
            if (ob_valid[n] !== ex_valid[n] || ob_car[n] !== ex_car[n] || ob_data[n] !== ex_data[n]) begin
                errors++;
                $display("FAIL random cycle %0d: valid/carrier/dataout=%0b/%0b/%h, want %0b/%0b/%h",
                         n, ob_valid[n], ob_car[n], ob_data[n], ex_valid[n], ex_car[n], ex_data[n]);
            end
            if (ob_valid[n]) pidx.push_back(n);
        end
        checks++;
        if (pidx.size() != 3) begin
            errors++;
            $display("FAIL random_pulses: got %0d valid pulses, want 3", pidx.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (pidx[k] != pos + LAT + (k + 1) * WORD_CYC - 1 || ob_data[pidx[k]] !== w[k]) begin
                    errors++;
                    $display("FAIL random_word%0d: pulse at %0d data %h, want %0d data %h",
                             k, pidx[k], ob_data[pidx[k]], pos + LAT + (k + 1) * WORD_CYC - 1, w[k]);
                end
            end
        end
    endtask

    task automatic test_glitch();
        int ncar;
        do_reset();
        clear_stim(130);
        tog[10] = 1'b1;
        tog[11] = 1'b1;
        tog[70] = 1'b1;
        tog[71] = 1'b1;
        build_expected('0);
        run_line();
        ncar = 0;
        for (int n = 0; n < nlen; n++) begin
            checks++;
            if (ob_valid[n] !== ex_valid[n] || ob_car[n] !== ex_car[n] || ob_data[n] !== ex_data[n]) begin
                errors++;
                $display("FAIL glitch cycle %0d: valid/carrier/dataout=%0b/%0b/%h, want %0b/%0b/%h",
                         n, ob_valid[n], ob_car[n], ob_data[n], ex_valid[n], ex_car[n], ex_data[n]);
            end
            if (ob_car[n]) ncar++;
        end
`ifdef FSK_DEMOD_GLITCH_FILTER_EN
        checks++;
        if (ncar != 0) begin
            errors++;
            $display("FAIL glitch_filtered: carrier high for %0d cycles, want 0", ncar);
        end
`else
        // Pulse edges land at 12 and 13; window 1 (28..43) is silent.
        checks++;
        if (ob_car[11] !== 1'b0 || ob_car[12] !== 1'b1 || ob_car[42] !== 1'b1 || ob_car[43] !== 1'b0) begin
            errors++;
            $display("FAIL glitch_unfiltered: carrier at 11/12/42/43 = %0b%0b%0b%0b, want 0110",
                     ob_car[11], ob_car[12], ob_car[42], ob_car[43]);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_carrier_loss();
        test_threshold();
        test_random_words();
        test_glitch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fsk_zc_demod.md
# fsk_zc_demod

Zero-crossing FSK demodulator and word assembler for the receive path. It takes the single-bit FSK line from the transmitter (modulated at clk2 rate) and oversamples it on the receiver clock. It counts signal transitions in each bit window to slice mark/space, then packs WORD_BITS sliced bits MSB-first into a 12-bit Hamming codeword for rHammingCode. It also detects carrier loss and re-acquires bit timing on the next transition.

## Interface
Parameters:
- SAMPLES_PER_BIT, 16: receiver clock cycles per transmitted bit.
- WORD_BITS, 12: bits per codeword, equal to the Hamming codeword width.
- EDGE_THRESH, 6: a window with at least this many edges slices to 1; fewer slices to 0.

Ports:
- clk  in  1  receiver oversampling clock (clk32 domain). Single clock; no other clocks.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- datain  in  1  raw FSK line, asynchronous to clk.
- dataout  out  WORD_BITS  last completed codeword; holds until the next word completes.
- valid  out  1  one-cycle pulse when dataout is updated.
- carrier  out  1  high while the bit timing is locked (state ACQ).

## Operation
- Input conditioning: two-flop synchronizer, then an edge flag = sync2 XOR sync3. An input change sampled at clk edge t raises the edge flag in cycle t+2.
- States:
  - IDLE: all counters at 0, carrier=0. The first edge flag moves the FSM to ACQ. That cycle E is cycle 0 of bit window 0, and its edge counts as 1.
  - ACQ: a sample counter counts 0..SAMPLES_PER_BIT-1. The edge counter accumulates edge flags and saturates at SAMPLES_PER_BIT.
- Bit slicing, on the last cycle of each window:
  - Bit = (edge count including this cycle ≥ EDGE_THRESH).
  - The bit shifts into the LSB of the assembly register, so the first bit received ends up as the MSB.
  - Edge counter and sample counter restart for the next window; the edge counter's restart value is this cycle's edge flag.
- Word completion: when bit WORD_BITS-1 is sliced, dataout takes the assembled word and valid pulses on the next cycle. The bit counter wraps to 0. The FSM stays in ACQ and the next window starts with no gap, so back-to-back words are supported.
- Carrier loss: a window that ends with edge count 0 discards the partial word and forces IDLE. carrier falls on the following cycle; valid does not pulse; dataout keeps its old value.
- Edge count equal to EDGE_THRESH exactly slices to 1.
- Edges are never used to re-align the window in ACQ; alignment is only taken on the IDLE-to-ACQ transition.
- Reset values: dataout=0, valid=0, carrier=0, FSM=IDLE, all counters and synchronizers 0.

## Timing
- Window k spans cycles E+k·SAMPLES_PER_BIT to E+k·SAMPLES_PER_BIT+SAMPLES_PER_BIT-1.
- valid asserts in cycle E+WORD_BITS·SAMPLES_PER_BIT (E+192 at defaults). dataout changes in that same cycle.
- Consecutive valid pulses are exactly WORD_BITS·SAMPLES_PER_BIT cycles apart while the carrier persists.
- carrier rises in cycle E+1.
- Reset asserted mid-word: outputs clear asynchronously and the partial word is lost. After release the block waits in IDLE for an edge.
- Pin-to-edge-flag latency is 2 cycles, or 3 with the glitch filter.

## Configuration
- FSK_DEMOD_GLITCH_FILTER_EN defined: a majority-of-3 filter over the last three synchronized samples sits between the synchronizer and the edge detector. Single-cycle glitches produce no edge. Pin-to-edge latency becomes 3 cycles.
- Undefined: no filter; every synchronized change counts as an edge.

## Structure
- Shared package fsk_pkg holds:
  - the state enum (IDLE, ACQ);
  - defaults FSK_SAMPLES_PER_BIT=16, FSK_WORD_BITS=12, FSK_EDGE_THRESH=6;
  - a counter-width function (clog2(n+1)).
- One sub-module, fsk_edge_detect: synchronizer, optional glitch filter and edge-flag generation.
- fsk_zc_demod holds the FSM, the counters and the assembly register.

## Test plan
- Reset check: assert reset with datain toggling → dataout=0, valid=0, carrier=0 throughout; IDLE after release with datain held constant.
- Single word: drive 12'hA5C, mark toggling every 2 cycles (8 edges per window), space every 4 cycles (4 edges) → exactly one valid at E+192 with dataout=12'hA5C, carrier=1.
- Back-to-back words: 12'h000 then 12'hFFF with no gap → valid pulses 192 cycles apart, values 12'h000 then 12'hFFF.
- Carrier loss: hold datain constant after 5 bits of a word → no valid; carrier falls one cycle after the empty window ends. Then send 12'h3C3 → decoded correctly with fresh alignment.
- Threshold boundary: one window with exactly 6 edges and one with exactly 5 → sliced 1 and 0 respectively.
- Glitch filter: with FSK_DEMOD_GLITCH_FILTER_EN, one-cycle pulses on an idle line → stays IDLE. Without the macro, the same stimulus → enters ACQ, then drops to IDLE after a zero-edge window.
